vga_timing_gen: RTL



---
 rtl/vga_pkg.sv | 47 ++++
 rtl/vga_pattern.sv | 58 +++++
 rtl/vga_timing_gen.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions: pattern mode encodings, the timing record and the
// standard 640x480@60 timing set used as parameter defaults.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_BLACK   = 2'd0,
    MODE_BARS    = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_EXT     = 2'd3
  } vga_mode_e;

  typedef struct packed {
    int unsigned h_active;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_active;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
  } vga_timing_t;

  localparam int unsigned VGA640_H_ACTIVE = 640;
  localparam int unsigned VGA640_H_FP     = 16;
  localparam int unsigned VGA640_H_SYNC   = 96;
  localparam int unsigned VGA640_H_BP     = 48;
  localparam int unsigned VGA640_V_ACTIVE = 480;
  localparam int unsigned VGA640_V_FP     = 10;
  localparam int unsigned VGA640_V_SYNC   = 2;
  localparam int unsigned VGA640_V_BP     = 33;

  localparam vga_timing_t VGA_640X480_60 = '{
    h_active: VGA640_H_ACTIVE, h_fp: VGA640_H_FP,
    h_sync:   VGA640_H_SYNC,   h_bp: VGA640_H_BP,
    v_active: VGA640_V_ACTIVE, v_fp: VGA640_V_FP,
    v_sync:   VGA640_V_SYNC,   v_bp: VGA640_V_BP
  };

  function automatic int unsigned line_total(input vga_timing_t t);
    return t.h_active + t.h_fp + t.h_sync + t.h_bp;
  endfunction

  function automatic int unsigned frame_total(input vga_timing_t t);
    return t.v_active + t.v_fp + t.v_sync + t.v_bp;
  endfunction

endpackage

// File: rtl/vga_pattern.sv
// Test-pattern colour source: colour bars, checkerboard and external RGB.
// Output is combinational; the top registers it on the pixel strobe.
module vga_pattern
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int COLOR_W  = 8
) (
  input  logic                   csi_clk,
  input  logic                   csi_reset_n,
  input  logic                   pix_en,
  input  logic                   line_end,
  input  logic                   chk_bit,
  input  logic [1:0]             mode,
  input  logic [3*COLOR_W-1:0]   ext_rgb,
  output logic [3*COLOR_W-1:0]   rgb
);

  localparam int BAR_W  = H_ACTIVE / 8;
  localparam int BAR_PW = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [BAR_PW-1:0] BAR_LAST = BAR_PW'(BAR_W - 1);

  logic [BAR_PW-1:0] bar_px;
  logic [2:0]        bar_idx;

  // Bar counters track the pixel currently on the counters, so they are
  // cleared when the line wraps and hold zero while h is 0.
  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (pix_en) begin
      if (line_end) begin
        bar_px  <= '0;
        bar_idx <= '0;
      end else if (bar_px == BAR_LAST) begin
        bar_px  <= '0;
        bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_px <= bar_px + BAR_PW'(1);
      end
    end
  end

  always_comb begin
    rgb = '0;
    case (vga_mode_e'(mode))
      MODE_BLACK:   rgb = '0;
      MODE_BARS:    rgb = {{COLOR_W{~bar_idx[1]}},
                           {COLOR_W{~bar_idx[2]}},
                           {COLOR_W{~bar_idx[0]}}};
      MODE_CHECKER: rgb = {(3*COLOR_W){chk_bit}};
      MODE_EXT:     rgb = ext_rgb;
      default:      rgb = '0;
    endcase
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel-enable divider, h/v counters,
// frame-latched pattern mode and a registered sync/blank/colour output stage.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = VGA640_H_ACTIVE,
  parameter int H_FP      = VGA640_H_FP,
  parameter int H_SYNC    = VGA640_H_SYNC,
  parameter int H_BP      = VGA640_H_BP,
  parameter int V_ACTIVE  = VGA640_V_ACTIVE,
  parameter int V_FP      = VGA640_V_FP,
  parameter int V_SYNC    = VGA640_V_SYNC,
  parameter int V_BP      = VGA640_V_BP,
  parameter bit SYNC_POL  = 1'b0,
  parameter int CLK_DIV   = 2,
  parameter int COLOR_W   = 8,
  parameter int CHK_SHIFT = 5
) (
  input  logic                                          csi_clk,
  input  logic                                          csi_reset_n,
  input  logic [1:0]                                    coe_mode,
  input  logic [3*COLOR_W-1:0]                          coe_ext_rgb,
  output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]  coe_x,
  output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]  coe_y,
  output logic                                          coe_pix_en,
  output logic                                          coe_frame_start,
  output logic                                          coe_hsync,
  output logic                                          coe_vsync,
  output logic                                          coe_blank_n,
  output logic [COLOR_W-1:0]                            coe_red,
  output logic [COLOR_W-1:0]                            coe_green,
  output logic [COLOR_W-1:0]                            coe_blue
);

  localparam vga_timing_t TIMING = '{
    h_active: H_ACTIVE, h_fp: H_FP, h_sync: H_SYNC, h_bp: H_BP,
    v_active: V_ACTIVE, v_fp: V_FP, v_sync: V_SYNC, v_bp: V_BP
  };
  localparam int H_TOTAL = line_total(TIMING);
  localparam int V_TOTAL = frame_total(TIMING);
  localparam int X_W     = $clog2(H_TOTAL);
  localparam int Y_W     = $clog2(V_TOTAL);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [X_W-1:0]   H_LAST   = X_W'(H_TOTAL - 1);
  localparam logic [Y_W-1:0]   V_LAST   = Y_W'(V_TOTAL - 1);

  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

  logic [DIV_W-1:0]     div_cnt;
  logic [DIV_W-1:0]     div_next;
  logic                 pix_en;
  logic [X_W-1:0]       h_cnt;
  logic [Y_W-1:0]       v_cnt;
  vga_mode_e            mode_q;
  vga_mode_e            mode_in;
  vga_mode_e            mode_eff;
  logic                 frame_start;
  logic                 line_end;
  logic                 active;
  logic                 hs;
  logic                 vs;
  logic                 chk_bit;
  logic [3*COLOR_W-1:0] pattern_rgb;
  logic [3*COLOR_W-1:0] rgb_q;
  logic                 blank_q;
  logic                 hsync_q;
  logic                 vsync_q;

  always_comb begin
    div_next = div_cnt + DIV_W'(1);
    if (div_cnt == DIV_LAST) div_next = '0;
  end

  // pix_en is registered so it stays low in reset even when CLK_DIV is 1;
  // out of reset it is high exactly while div_cnt sits at its last value.
  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      div_cnt <= '0;
      pix_en  <= 1'b0;
    end else begin
      div_cnt <= div_next;
      pix_en  <= (div_next == DIV_LAST);
    end
  end

  assign line_end    = (h_cnt == H_LAST);
  assign frame_start = pix_en && (h_cnt == '0) && (v_cnt == '0);

  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (line_end) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + Y_W'(1);
      end else begin
        h_cnt <= h_cnt + X_W'(1);
      end
    end
  end

  // The newly requested mode already applies to the frame-start pixel itself.
  assign mode_in  = vga_mode_e'(coe_mode);
  assign mode_eff = frame_start ? mode_in : mode_q;

  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) mode_q <= MODE_BLACK;
    else if (frame_start) mode_q <= mode_in;
  end

  assign active  = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
  assign hs      = (int'(h_cnt) >= HS_START) && (int'(h_cnt) < HS_END);
  assign vs      = (int'(v_cnt) >= VS_START) && (int'(v_cnt) < VS_END);
  assign chk_bit = h_cnt[CHK_SHIFT] ^ v_cnt[CHK_SHIFT];

  vga_pattern #(
    .H_ACTIVE (H_ACTIVE),
    .COLOR_W  (COLOR_W)
  ) u_pattern (
    .csi_clk     (csi_clk),
    .csi_reset_n (csi_reset_n),
    .pix_en      (pix_en),
    .line_end    (line_end),
    .chk_bit     (chk_bit),
    .mode        (mode_eff),
    .ext_rgb     (coe_ext_rgb),
    .rgb         (pattern_rgb)
  );

  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      blank_q <= 1'b0;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      rgb_q   <= '0;
    end else if (pix_en) begin
      blank_q <= active;
      hsync_q <= hs ? SYNC_POL : ~SYNC_POL;
      vsync_q <= vs ? SYNC_POL : ~SYNC_POL;
      rgb_q   <= active ? pattern_rgb : '0;
    end
  end

  assign coe_x           = h_cnt;
  assign coe_y           = v_cnt;
  assign coe_pix_en      = pix_en;
  assign coe_frame_start = frame_start;
  assign coe_hsync       = hsync_q;
  assign coe_vsync       = vsync_q;
  assign coe_blank_n     = blank_q;
  assign coe_red         = rgb_q[3*COLOR_W-1 -: COLOR_W];
  assign coe_green       = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign coe_blue        = rgb_q[COLOR_W-1:0];

endmodule
